main_data_writer: RTL and testbench

Writer side of the bit reservoir. Takes the byte stream of one synchronised MPEG-1 Layer III frame from frame sync and parses the 4 header bytes itself. It skips the optional 2 CRC bytes, forwards the side-information bytes to the side-info parser, and serialises every main-data byte MSB-first into the 1-bit reservoir FIFO, honouring FIFO backpressure. The reservoir read side (discard / scalefactor / Huffman routing) consumes what this block writes.

---
 rtl/main_data_writer.sv | 168 ++++++++++++++++
 tb/tb_main_data_writer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_data_writer.sv
// Bit-reservoir writer: parses an MPEG-1 Layer III frame header, drops the CRC bytes, forwards
// the side info, and serialises the main data MSB-first into the 1-bit reservoir FIFO.
module main_data_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        frame_start,
  input  logic [10:0] frame_bytes,
  output logic [7:0]  si_byte,
  output logic        si_valid,
  output logic        si_last,
  output logic        fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic        frame_done,
  output logic        frame_error
);

  typedef enum logic [2:0] {StIdle, StHeader, StCrc, StSide, StMain} state_e;

  state_e      state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] frame_bytes_q, frame_bytes_d;
  logic        crc_en_q, crc_en_d;
  logic [5:0]  si_len_q, si_len_d;
  logic [7:0]  sr_q, sr_d;
  logic [3:0]  bc_q, bc_d;
  logic        last_q, last_d;
  logic [7:0]  si_byte_q, si_byte_d;
  logic        si_valid_q, si_valid_d;
  logic        si_last_q, si_last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [10:0] side_base;
  logic        side_end;
  logic [11:0] main_len;
  logic        main_bad;

  assign side_base = crc_en_q ? 11'd6 : 11'd4;
  assign side_end  = (byte_cnt_q + 11'd1) == (side_base + {5'd0, si_len_q});
  assign main_len  = {1'b0, frame_bytes_q} - {1'b0, side_base} - {6'd0, si_len_q};
  assign main_bad  = main_len[11] || (main_len == 12'd0);

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    frame_bytes_d = frame_bytes_q;
    crc_en_d      = crc_en_q;
    si_len_d      = si_len_q;
    sr_d          = sr_q;
    bc_d          = bc_q;
    last_d        = last_q;
    si_byte_d     = si_byte_q;
    si_valid_d    = 1'b0;
    si_last_d     = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    byte_ready    = 1'b1;

    // bc is only ever non-zero in StMain, so the write strobe needs no state qualifier.
    fifo_wr_en = (bc_q != 4'd0) && !fifo_full;
    fifo_din   = sr_q[7];

    // Once the final main byte is loaded, hold off further bytes until it drains.
    if (state_q == StMain) begin
      byte_ready = !last_q && ((bc_q == 4'd0) || ((bc_q == 4'd1) && !fifo_full));
    end
    accept = byte_valid && byte_ready;

    if (fifo_wr_en) begin
      sr_d = {sr_q[6:0], 1'b0};
      bc_d = bc_q - 4'd1;
      if (last_q && (bc_q == 4'd1)) begin
        done_d  = 1'b1;
        last_d  = 1'b0;
        state_d = StIdle;
      end
    end

    if (accept) begin
      if (frame_start) begin
        frame_bytes_d = frame_bytes;
        byte_cnt_d    = 11'd1;
        state_d       = StHeader;
        sr_d          = 8'd0;
        bc_d          = 4'd0;
        last_d        = 1'b0;
        err_d         = (state_q != StIdle);
      end else begin
        unique case (state_q)
          StIdle: ;
          StHeader: begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (byte_cnt_q == 11'd1) crc_en_d = ~byte_in[0];
            if (byte_cnt_q == 11'd3) begin
              si_len_d = (byte_in[7:6] == 2'b11) ? 6'd17 : 6'd32;
              state_d  = crc_en_q ? StCrc : StSide;
            end
          end
          StCrc: begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (byte_cnt_q == 11'd5) state_d = StSide;
          end
          StSide: begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            si_byte_d  = byte_in;
            si_valid_d = 1'b1;
            si_last_d  = side_end;
            if (side_end) begin
              err_d   = main_bad;
              state_d = main_bad ? StIdle : StMain;
            end
          end
          StMain: begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            sr_d       = byte_in;
            bc_d       = 4'd8;
            last_d     = (byte_cnt_q + 11'd1) == frame_bytes_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      byte_cnt_q    <= 11'd0;
      frame_bytes_q <= 11'd0;
      crc_en_q      <= 1'b0;
      si_len_q      <= 6'd32;
      sr_q          <= 8'd0;
      bc_q          <= 4'd0;
      last_q        <= 1'b0;
      si_byte_q     <= 8'd0;
      si_valid_q    <= 1'b0;
      si_last_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_bytes_q <= frame_bytes_d;
      crc_en_q      <= crc_en_d;
      si_len_q      <= si_len_d;
      sr_q          <= sr_d;
      bc_q          <= bc_d;
      last_q        <= last_d;
      si_byte_q     <= si_byte_d;
      si_valid_q    <= si_valid_d;
      si_last_q     <= si_last_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign si_byte     = si_byte_q;
  assign si_valid    = si_valid_q;
  assign si_last     = si_last_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_main_data_writer.sv
// Directed bench for main_data_writer: a frame-level model predicts side-info bytes, reservoir
// bits and done/error pulses; a negedge monitor checks every output event against it.
module tb_main_data_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_start;
  logic [10:0] frame_bytes;
  logic [7:0]  si_byte;
  logic        si_valid;
  logic        si_last;
  logic        fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        frame_done;
  logic        frame_error;

  main_data_writer dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_start (frame_start),
    .frame_bytes (frame_bytes),
    .si_byte     (si_byte),
    .si_valid    (si_valid),
    .si_last     (si_last),
    .fifo_din    (fifo_din),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] si_q[$];
  logic       bit_q[$];
  logic [8:0] si_exp;
  int         exp_done, exp_err;
  int         si_cnt, wr_cnt, done_cnt, err_cnt, first_wr, last_wr;
  int         cyc = 0;
  logic       prev_wr = 1'b0;
  logic [7:0] first_si;
  logic       first_si_seen;
  logic       stall_en = 1'b0;
  logic [7:0] frm [0:2047];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor
  always @(negedge clk) begin
    cyc++;
    if (si_valid) begin
      si_cnt++;
      if (!first_si_seen) begin
        first_si      = si_byte;
        first_si_seen = 1'b1;
      end
      if (si_q.size() == 0) begin
        check("si_unexpected", 1, 0);
      end else begin
        si_exp = si_q.pop_front();
        check("si_byte", si_byte, si_exp[7:0]);
        check("si_last", si_last, si_exp[8]);
      end
    end
    if (fifo_wr_en) begin
      check("wr_while_full", fifo_full, 0);
      wr_cnt++;
      if (wr_cnt == 1) first_wr = cyc;
      last_wr = cyc;
      if (bit_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("fifo_din", fifo_din, bit_q.pop_front());
    end
    if (frame_done) begin
      done_cnt++;
      check("done_after_last_write", (prev_wr && bit_q.size() == 0) ? 1 : 0, 1);
    end
    if (frame_error) err_cnt++;
    prev_wr = fifo_wr_en;
  end

  initial begin
    fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fifo_full = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    si_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_wr = 0; last_wr = 0; first_si_seen = 1'b0; first_si = 8'd0;
    exp_done = 0; exp_err = 0;
  endtask

  task automatic build(input bit stereo, input bit crc, input int seed);
    frm[0] = 8'hFF;
    frm[1] = crc ? 8'hFA : 8'hFB;
    frm[2] = 8'h90;
    frm[3] = stereo ? 8'h00 : 8'hC0;
    for (int i = 4; i < 2048; i++) frm[i] = 8'((i * 7 + seed) & 255);
  endtask

  // n_main < 0: whole frame sent; otherwise only n_main main bytes precede an abort.
  task automatic model(input int fb, input int n_main);
    int hdr, sil, ml, nm;
    hdr = frm[1][0] ? 4 : 6;
    sil = (frm[3][7:6] == 2'b11) ? 17 : 32;
    for (int k = 0; k < sil; k++) si_q.push_back({(k == sil - 1), frm[hdr + k]});
    ml = fb - hdr - sil;
    if (ml <= 0) begin
      exp_err++;
    end else begin
      nm = (n_main < 0) ? ml : n_main;
      for (int j = 0; j < nm; j++)
        for (int b = 7; b >= 0; b--) bit_q.push_back(frm[hdr + sil + j][b]);
      if (n_main < 0) exp_done++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs, input logic [10:0] fb);
    int   n;
    logic acc;
    byte_in     = b;
    byte_valid  = 1'b1;
    frame_start = fs;
    frame_bytes = fb;
    acc         = 1'b0;
    n           = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (byte_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("byte_accept_timeout", 0, 1);
    byte_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send(input int first, input int last_idx, input int fb);
    for (int i = first; i <= last_idx; i++) send_byte(frm[i], (i == 0), 11'(fb));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(si_q.size() == 0 && bit_q.size() == 0 &&
                           done_cnt == exp_done && err_cnt == exp_err)) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", (n < budget) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, exp_done);
    check("error_count", err_cnt, exp_err);
  endtask

  initial begin
    rst = 1'b1; byte_in = 8'd0; byte_valid = 1'b0; frame_start = 1'b0; frame_bytes = 11'd0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 1);
    check("rst_si_valid", si_valid, 0);
    check("rst_si_last", si_last, 0);
    check("rst_si_byte", si_byte, 0);
    check("rst_fifo_wr_en", fifo_wr_en, 0);
    check("rst_fifo_din", fifo_din, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_error", frame_error, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Stray bytes in idle must be dropped silently.
    send_byte(8'h12, 1'b0, 11'd0);
    send_byte(8'hFF, 1'b0, 11'd0);
    send_byte(8'h34, 1'b0, 11'd0);

    // Stereo, no CRC, 417 bytes
    clear_stats();
    build(1'b1, 1'b0, 1);
    model(417, -1);
    send(0, 416, 417);
    wait_idle(200);
    check("t1_si_count", si_cnt, 32);
    check("t1_wr_count", wr_cnt, 3048);
    check("t1_wr_contiguous", last_wr - first_wr + 1, 3048);
    check("t1_first_si", first_si, 8'h1D);

    // Mono with CRC, 208 bytes
    clear_stats();
    build(1'b0, 1'b1, 3);
    model(208, -1);
    send(0, 207, 208);
    wait_idle(200);
    check("t2_si_count", si_cnt, 17);
    check("t2_wr_count", wr_cnt, 1480);
    check("t2_first_si", first_si, 8'h2D);

    // Random reservoir backpressure
    clear_stats();
    build(1'b1, 1'b0, 1);
    model(417, -1);
    stall_en = 1'b1;
    send(0, 416, 417);
    wait_idle(500);
    stall_en = 1'b0;
    check("t3_wr_count", wr_cnt, 3048);

    // New frame_start after 100 main bytes
    clear_stats();
    build(1'b1, 1'b0, 5);
    model(417, 100);
    exp_err++;
    send(0, 135, 417);
    build(1'b0, 1'b0, 9);
    model(150, -1);
    send(0, 149, 150);
    wait_idle(200);
    check("t4_si_count", si_cnt, 49);
    check("t4_wr_count", wr_cnt, 1832);

    // frame_bytes too small for the side info
    clear_stats();
    build(1'b1, 1'b0, 7);
    model(30, -1);
    send(0, 35, 30);
    wait_idle(200);
    check("t5_si_count", si_cnt, 32);
    check("t5_wr_count", wr_cnt, 0);
    check("t5_err_count", err_cnt, 1);

    // Reset in the middle of side info, then a fresh frame
    clear_stats();
    build(1'b1, 1'b0, 11);
    for (int k = 0; k < 10; k++) si_q.push_back({1'b0, frm[4 + k]});
    send(0, 13, 417);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_quiet_after_rst", si_cnt + wr_cnt, 10);
    build(1'b1, 1'b0, 13);
    model(417, -1);
    send(0, 416, 417);
    wait_idle(200);
    check("t6_si_count", si_cnt, 42);
    check("t6_wr_count", wr_cnt, 3048);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
